ex_mem_latch: RTL

EX_MEM_LATCH -- requirements
Module: ex_mem_latch

---
 rtl/ex_mem_latch.sv | 116 +++++++++++
 1 files changed

// File: rtl/ex_mem_latch.sv
// EX/MEM pipeline register with stall/flush control, forward-hit detection
// against the instruction in EX, and a saturating bubble counter.
`default_nettype none

module ex_mem_latch #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [1:0]        ctlwb_in,
    input  logic [2:0]        ctlm_in,
    input  logic [DATA_W-1:0] adder_in,
    input  logic              aluzero_in,
    input  logic [DATA_W-1:0] aluout_in,
    input  logic [DATA_W-1:0] readdat2_in,
    input  logic [4:0]        muxout_in,
    input  logic [4:0]        idex_rs,
    input  logic [4:0]        idex_rt,
    input  logic              clr_cnt,
    output logic              out_valid,
    output logic [1:0]        wb_ctlout,
    output logic              branch,
    output logic              memread,
    output logic              memwrite,
    output logic [DATA_W-1:0] add_result,
    output logic              zero,
    output logic [DATA_W-1:0] alu_result,
    output logic [DATA_W-1:0] rdata2out,
    output logic [4:0]        five_bit_muxout,
    output logic              fwd_rs,
    output logic              fwd_rt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic              r_valid;
    logic [1:0]        r_wb;
    logic [2:0]        r_m;
    logic [DATA_W-1:0] r_add;
    logic              r_zero;
    logic [DATA_W-1:0] r_alu;
    logic [DATA_W-1:0] r_rdat2;
    logic [4:0]        r_dst;
    logic [CNT_W-1:0]  r_cnt;

    logic w_load;
    logic w_bubble;
    logic w_dst_live;

    assign w_load   = !flush && !stall;
    // A bubble is either an explicit flush or a load of a non-instruction.
    assign w_bubble = flush || (w_load && !in_valid);

    // Pipeline payload: flush clears only validity/control, data holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_wb    <= 2'b00;
            r_m     <= 3'b000;
            r_add   <= '0;
            r_zero  <= 1'b0;
            r_alu   <= '0;
            r_rdat2 <= '0;
            r_dst   <= 5'd0;
        end else if (flush) begin
            r_valid <= 1'b0;
            r_wb    <= 2'b00;
            r_m     <= 3'b000;
        end else if (!stall) begin
            r_valid <= in_valid;
            r_wb    <= in_valid ? ctlwb_in : 2'b00;
            r_m     <= in_valid ? ctlm_in : 3'b000;
            r_add   <= adder_in;
            r_zero  <= aluzero_in;
            r_alu   <= aluout_in;
            r_rdat2 <= readdat2_in;
            r_dst   <= muxout_in;
        end
    end

    // clr_cnt wins over both increment and stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr_cnt) begin
            r_cnt <= '0;
        end else if (w_bubble && !(&r_cnt)) begin
            r_cnt <= r_cnt + c_CNT_ONE;
        end
    end

    // Register 0 is hardwired and must never be forwarded.
    assign w_dst_live = r_valid && r_wb[1] && (r_dst != 5'd0);

    assign fwd_rs          = w_dst_live && (r_dst == idex_rs);
    assign fwd_rt          = w_dst_live && (r_dst == idex_rt);
    assign out_valid       = r_valid;
    assign wb_ctlout       = r_wb;
    assign branch          = r_m[2];
    assign memread         = r_m[1];
    assign memwrite        = r_m[0];
    assign add_result      = r_add;
    assign zero            = r_zero;
    assign alu_result      = r_alu;
    assign rdata2out       = r_rdat2;
    assign five_bit_muxout = r_dst;
    assign bubble_cnt      = r_cnt;

endmodule

`default_nettype wire
